// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end: default PC geometry
// and the next-PC source encoding used by the program-counter unit.
package mips_pkg;

  localparam int unsigned PC_WIDTH_DEF     = 16;
  localparam int unsigned RESET_VECTOR_DEF = 0;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_JUMP   = 2'd1,
    NPC_BRANCH = 2'd2,
    NPC_RET    = 2'd3
  } npc_sel_e;

endpackage : mips_pkg

// File: rtl/pc_ras.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry; overflow/underflow are single-cycle pulses for the owner to latch.
module pc_ras #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [PTR_W-1:0] top_idx;
  logic             do_push, do_pop;

  // ptr_reg is the next free slot; when full it also addresses the oldest entry.
  assign top_idx  = ptr_reg - PTR_W'(1);
  assign top_data = mem[top_idx];
  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CNT_MAX);

  always_comb begin
    do_push   = 1'b0;
    do_pop    = 1'b0;
    overflow  = 1'b0;
    underflow = 1'b0;
    if (pop) begin
      do_pop    = !empty;
      underflow = empty;
    end else if (push) begin
      do_push  = 1'b1;
      overflow = full;
    end
  end

  always_comb begin
    ptr_next   = ptr_reg;
    count_next = count_reg;
    if (do_pop) begin
      ptr_next   = ptr_reg - PTR_W'(1);
      count_next = count_reg - CNT_W'(1);
    end else if (do_push) begin
      ptr_next = ptr_reg + PTR_W'(1);
      if (!full) begin
        count_next = count_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg   <= '0;
      count_reg <= '0;
    end else begin
      ptr_reg   <= ptr_next;
      count_reg <= count_next;
    end
  end

  // Entries are not reset: a zero count already makes old contents unreachable.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (!rst && do_push && (ptr_reg == PTR_W'(gi))) begin
        mem[gi] <= push_data;
      end
    end
  end

endmodule : pc_ras

// File: rtl/pc_unit.sv
// Fetch-stage program counter: priority next-PC mux (branch > ret > call >
// jump > sequential), stall via ce, and a return-address stack for call/ret.
module pc_unit
  import mips_pkg::*;
#(
  parameter int unsigned PC_WIDTH     = PC_WIDTH_DEF,
  parameter int unsigned STEP         = 1,
  parameter int unsigned RESET_VECTOR = RESET_VECTOR_DEF,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                branch_en,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                jump_en,
  input  logic                call_en,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                ret_en,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus,
  output logic                ras_empty,
  output logic                ras_full,
  output logic                ras_err
);

  logic [PC_WIDTH-1:0] pc_reg, pc_next;
  logic                err_reg, err_next;
  npc_sel_e            npc_sel;
  logic                ras_push, ras_pop;
  logic [PC_WIDTH-1:0] ras_top;
  logic                ras_overflow, ras_underflow;

  assign pc      = pc_reg;
  assign pc_plus = pc_reg + PC_WIDTH'(STEP);
  assign ras_err = err_reg;

  // A branch squashes everything from ID; ret beats call; call beats jump.
  always_comb begin
    npc_sel  = NPC_SEQ;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (ce) begin
      if (branch_en) begin
        npc_sel = NPC_BRANCH;
      end else if (ret_en) begin
        ras_pop = 1'b1;
        npc_sel = ras_empty ? NPC_SEQ : NPC_RET;
      end else if (call_en) begin
        ras_push = 1'b1;
        npc_sel  = NPC_JUMP;
      end else if (jump_en) begin
        npc_sel = NPC_JUMP;
      end
    end
  end

  always_comb begin
    pc_next = pc_plus;
    unique case (npc_sel)
      NPC_SEQ:    pc_next = pc_plus;
      NPC_JUMP:   pc_next = jump_target;
      NPC_BRANCH: pc_next = branch_target;
      NPC_RET:    pc_next = ras_top;
      default:    pc_next = pc_plus;
    endcase
  end

  assign err_next = err_reg | ras_overflow | ras_underflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg  <= PC_WIDTH'(RESET_VECTOR);
      err_reg <= 1'b0;
    end else if (ce) begin
      pc_reg  <= pc_next;
      err_reg <= err_next;
    end
  end

  pc_ras #(
    .WIDTH (PC_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

endmodule : pc_unit

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the pipelined MIPS fetch stage; successor to the plain clock-enabled PC register.
Holds the fetch PC and selects the next PC from a sequential increment, a jump/call target, a branch redirect or a return-address-stack (RAS) pop.
Stalls via clock enable and resets to a configurable vector.
Sits ahead of instruction memory; branch redirects come from the EX stage, jump/call/ret from ID.

Parameters:
PC_WIDTH, 16, width of PC and all address ports
STEP, 1, sequential increment (1 = word-addressed memory)
RESET_VECTOR, 0, PC value loaded on reset
RAS_DEPTH, 4, return-address-stack entries (power of two, >=2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
ce  in  1  update enable; 0 = stall, all state held
branch_en  in  1  EX-stage taken branch/mispredict redirect
branch_target  in  PC_WIDTH  branch redirect address
jump_en  in  1  ID-stage unconditional jump
call_en  in  1  ID-stage call (jump and push return address)
jump_target  in  PC_WIDTH  target for jump_en/call_en
ret_en  in  1  ID-stage return (pop RAS)
pc  out  PC_WIDTH  current fetch PC (registered)
pc_plus  out  PC_WIDTH  pc + STEP (combinational, modulo 2^PC_WIDTH)
ras_empty  out  1  RAS holds no valid entries
ras_full  out  1  RAS holds RAS_DEPTH entries
ras_err  out  1  sticky: overflow or underflow since reset

Behaviour:
- Reset: rst=1 at a rising edge -> pc=RESET_VECTOR, RAS count=0, top pointer=0, ras_empty=1, ras_full=0, ras_err=0. rst overrides ce and all requests. Reset mid-stream discards RAS contents.
- ce=0, rst=0: pc, RAS contents, pointer, count and ras_err all held; requests ignored, not queued.
- ce=1: next pc chosen by strict priority:
  1. branch_en -> branch_target; call/ret/jump in the same cycle are squashed, RAS untouched.
  2. ret_en, RAS non-empty -> popped top entry; count-1.
  3. ret_en, RAS empty -> pc_plus; ras_err set (underflow).
  4. call_en -> jump_target; push pc_plus; count+1 saturating at RAS_DEPTH.
  5. jump_en -> jump_target.
  6. otherwise -> pc_plus.
- ret_en and call_en both asserted: ret wins (rule 2/3), call ignored. jump_en and call_en both asserted: treated as call.
- RAS is circular. Push when full overwrites the oldest entry, count stays RAS_DEPTH, ras_err set (overflow). Pointer wraps modulo RAS_DEPTH.
- Latency: the selected next pc is visible on pc one cycle after the qualifying edge. No combinational path from inputs to pc.
- pc_plus wraps: pc=2^PC_WIDTH-STEP gives pc_plus=0.
- ras_empty = (count==0), ras_full = (count==RAS_DEPTH), both registered-state-derived.

Decomposition:
- Shared package mips_pkg: PC_WIDTH default, RESET_VECTOR default, next-PC select encoding (NPC_SEQ, NPC_JUMP, NPC_BRANCH, NPC_RET) as a typedef/localparams.
- Sub-module pc_ras: circular stack with push, pop, count, full/empty and overflow/underflow pulses.
- pc_unit instantiates pc_ras and contains the priority mux and PC register.

Test Plan:
- Reset/sequential: rst 1 cycle, ce=1, no requests for 4 cycles -> pc 0,1,2,3,4; pc_plus = pc+1.
- Stall: at pc=5 hold ce=0 for 3 cycles with jump_en=1, target 0x40 -> pc stays 5; on ce=1 with no requests -> pc=6.
- Call/return: at pc=0x10 call_en, target 0x80 -> pc=0x80, ras_empty=0; 2 seq cycles; ret_en -> pc=0x11, ras_empty=1.
- Priority: at pc=0x20 assert branch_en (target 0x100) with call_en (target 0x80) -> pc=0x100, RAS count unchanged; ret_en with call_en -> pop wins.
- Overflow/underflow: 5 calls from pcs 1..5 with RAS_DEPTH=4 -> ras_full=1, ras_err=1; 4 rets return 6,5,4,3; 5th ret -> pc=pc_plus, ras_empty=1.
- Wrap/reset mid-op: pc=0xFFFF seq -> pc=0x0000; rst asserted with ce=0 and RAS full -> pc=0, ras_empty=1, ras_err=0.
